// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem request handshake and
// keeps a single-entry output register toward decode with stall and redirect handling.
//
// state | meaning
// IDLE  | one bubble cycle after reset release
// READY | no request; waits for the output slot to free up
// REQ   | request phase; inst_addr_o held until inst_ack_i
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic        exc_flag_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ack_i,
    input  logic [31:0] inst_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_REQ   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic        pend, pend_nxt;
    logic [31:0] pend_tgt, pend_tgt_nxt;
    logic        valid_nxt;
    logic [31:0] inst_nxt, pc_nxt;

    logic        consume, slot_free, redir, req_live, ack;
    logic [31:0] redir_tgt;

    assign consume   = inst_valid_o & ~stall_i;
    assign slot_free = ~inst_valid_o | consume;
    assign redir     = exc_flag_i | branch_flag_i;
    assign redir_tgt = exc_flag_i ? {EXC_VECTOR[31:2], 2'b00}
                                  : {branch_target_address_i[31:2], 2'b00};

    // The slot can only be occupied on entry to REQ (after a back-to-back ack);
    // once it drains it stays empty until the next ack, so the request never
    // drops once raised.
    assign req_live    = (state == S_REQ) & slot_free;
    assign ack         = req_live & inst_ack_i;
    assign inst_req_o  = req_live;
    assign inst_addr_o = fetch_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            fetch_pc     <= RESET_PC;
            pend         <= 1'b0;
            pend_tgt     <= 32'h0;
            inst_valid_o <= 1'b0;
            inst_o       <= 32'h0;
            pc_o         <= 32'h0;
        end else begin
            state        <= state_nxt;
            fetch_pc     <= fetch_pc_nxt;
            pend         <= pend_nxt;
            pend_tgt     <= pend_tgt_nxt;
            inst_valid_o <= valid_nxt;
            inst_o       <= inst_nxt;
            pc_o         <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        pend_nxt     = pend;
        pend_tgt_nxt = pend_tgt;
        valid_nxt    = inst_valid_o & ~consume;
        inst_nxt     = inst_o;
        pc_nxt       = pc_o;

        case (state)
            S_IDLE:  state_nxt = S_READY;
            S_READY: if (slot_free) state_nxt = S_REQ;
            S_REQ: begin
                if (ack && !redir && !pend)
                    state_nxt = (consume || !inst_valid_o) ? S_REQ : S_READY;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (redir) begin
            valid_nxt = 1'b0;
            if (req_live && !ack) begin
                // Address must stay put until the ack; remember where to go.
                pend_nxt     = 1'b1;
                pend_tgt_nxt = redir_tgt;
            end else begin
                fetch_pc_nxt = redir_tgt;
                pend_nxt     = 1'b0;
            end
        end else if (ack) begin
            if (pend) begin
                fetch_pc_nxt = pend_tgt;
                pend_nxt     = 1'b0;
            end else begin
                valid_nxt    = 1'b1;
                inst_nxt     = inst_rdata_i;
                pc_nxt       = fetch_pc;
                fetch_pc_nxt = fetch_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a wait-state-configurable memory responder.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = 32'h0;
    logic        exc_flag_i = 1'b0;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_ack_i;
    logic [31:0] inst_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    int checks = 0;
    int failures = 0;
    int mem_wait = 0;
    int wait_cnt;

    fetch_ctrl dut (
        .clk(clk),
        .rst(rst),
        .stall_i(stall_i),
        .branch_flag_i(branch_flag_i),
        .branch_target_address_i(branch_target_address_i),
        .exc_flag_i(exc_flag_i),
        .inst_req_o(inst_req_o),
        .inst_addr_o(inst_addr_o),
        .inst_ack_i(inst_ack_i),
        .inst_rdata_i(inst_rdata_i),
        .inst_valid_o(inst_valid_o),
        .inst_o(inst_o),
        .pc_o(pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory: ack once the request has been up for mem_wait cycles.
    always_comb begin
        inst_ack_i   = inst_req_o && (wait_cnt >= mem_wait);
        inst_rdata_i = word(inst_addr_o);
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt <= 0;
        else if (inst_req_o && !inst_ack_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset, release on a falling edge, advance to the first REQ cycle.
    task automatic restart(input int w);
        @(negedge clk);
        rst = 1'b0;
        stall_i = 1'b0;
        branch_flag_i = 1'b0;
        exc_flag_i = 1'b0;
        mem_wait = w;
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        mem_wait = 0;
        #1;
        checks++;
        if (inst_req_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== 32'h0 ||
            pc_o !== 32'h0 || inst_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: req=%b valid=%b inst=%h pc=%h addr=%h, required 0/0/0/0/0",
                     inst_req_o, inst_valid_o, inst_o, pc_o, inst_addr_o);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (inst_req_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_bubble_req: got %b, required 0", inst_req_o);
        end
        tick();
        checks++;
        if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL first_req: req=%b addr=%h, required 1/00000000", inst_req_o, inst_addr_o);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (inst_valid_o !== 1'b1 || pc_o !== 32'(4 * k) || inst_o !== word(32'(4 * k))) begin
                failures++;
                $display("FAIL zero_wait_stream[%0d]: valid=%b pc=%h inst=%h, required 1/%h/%h",
                         k, inst_valid_o, pc_o, inst_o, 32'(4 * k), word(32'(4 * k)));
            end
        end
    endtask

    task automatic test_wait_states();
        restart(2);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (inst_req_o !== 1'b1 || inst_addr_o !== 32'(4 * k) || inst_ack_i !== (j == 2)) begin
                    failures++;
                    $display("FAIL wait_addr[%0d/%0d]: req=%b addr=%h ack=%b, required 1/%h/%b",
                             k, j, inst_req_o, inst_addr_o, inst_ack_i, 32'(4 * k), (j == 2));
                end
                if (j > 0) begin
                    checks++;
                    if (inst_valid_o !== 1'b0) begin
                        failures++;
                        $display("FAIL wait_bubble[%0d/%0d]: valid=%b, required 0", k, j, inst_valid_o);
                    end
                end
                tick();
            end
            checks++;
            if (inst_valid_o !== 1'b1 || pc_o !== 32'(4 * k) || inst_o !== word(32'(4 * k))) begin
                failures++;
                $display("FAIL wait_deliver[%0d]: valid=%b pc=%h inst=%h, required 1/%h/%h",
                         k, inst_valid_o, pc_o, inst_o, 32'(4 * k), word(32'(4 * k)));
            end
        end
    endtask

    task automatic test_stall();
        restart(0);
        tick();
        stall_i = 1'b1;
        #1;
        checks++;
        if (inst_req_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_req_gate: req=%b, required 0", inst_req_o);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== word(32'h0) || inst_req_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h inst=%h req=%b, required 1/00000000/%h/0",
                         c, inst_valid_o, pc_o, inst_o, inst_req_o, word(32'h0));
            end
        end
        stall_i = 1'b0;
        tick();
        checks++;
        if (inst_valid_o !== 1'b1 || pc_o !== 32'h4 || inst_o !== word(32'h4)) begin
            failures++;
            $display("FAIL stall_resume: valid=%b pc=%h inst=%h, required 1/00000004/%h",
                     inst_valid_o, pc_o, inst_o, word(32'h4));
        end
    endtask

    task automatic test_branch_wait();
        restart(2);
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            tick();
        end
        checks++;
        if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h10) begin
            failures++;
            $display("FAIL branch_setup: req=%b addr=%h, required 1/00000010", inst_req_o, inst_addr_o);
        end
        // Two redirects during the wait: the later target must win.
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h80;
        tick();
        branch_target_address_i = 32'h100;
        tick();
        branch_flag_i = 1'b0;
        checks++;
        if (inst_addr_o !== 32'h10 || inst_ack_i !== 1'b1 || inst_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL branch_addr_hold: addr=%h ack=%b valid=%b, required 00000010/1/0",
                     inst_addr_o, inst_ack_i, inst_valid_o);
        end
        tick();
        checks++;
        if (inst_valid_o !== 1'b0 || inst_addr_o !== 32'h100 || inst_req_o !== 1'b1) begin
            failures++;
            $display("FAIL branch_retarget: valid=%b addr=%h req=%b, required 0/00000100/1",
                     inst_valid_o, inst_addr_o, inst_req_o);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (inst_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL branch_no_wrong_path[%0d]: valid=%b pc=%h, required 0", c, inst_valid_o, pc_o);
            end
        end
        tick();
        checks++;
        if (inst_valid_o !== 1'b1 || pc_o !== 32'h100 || inst_o !== word(32'h100)) begin
            failures++;
            $display("FAIL branch_first_valid: valid=%b pc=%h inst=%h, required 1/00000100/%h",
                     inst_valid_o, pc_o, inst_o, word(32'h100));
        end
    endtask

    task automatic test_exc_priority();
        restart(0);
        tick();
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h200;
        exc_flag_i = 1'b1;
        tick();
        branch_flag_i = 1'b0;
        exc_flag_i = 1'b0;
        checks++;
        if (inst_valid_o !== 1'b0 || inst_addr_o !== 32'h380) begin
            failures++;
            $display("FAIL exc_priority: valid=%b addr=%h, required 0/00000380", inst_valid_o, inst_addr_o);
        end
        tick();
        checks++;
        if (inst_valid_o !== 1'b1 || pc_o !== 32'h380 || inst_o !== word(32'h380)) begin
            failures++;
            $display("FAIL exc_deliver: valid=%b pc=%h inst=%h, required 1/00000380/%h",
                     inst_valid_o, pc_o, inst_o, word(32'h380));
        end
        stall_i = 1'b1;
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h207;
        tick();
        branch_flag_i = 1'b0;
        checks++;
        if (inst_valid_o !== 1'b0 || inst_addr_o !== 32'h204) begin
            failures++;
            $display("FAIL branch_align_under_stall: valid=%b addr=%h, required 0/00000204",
                     inst_valid_o, inst_addr_o);
        end
        stall_i = 1'b0;
    endtask

    task automatic test_wrap_and_async_reset();
        restart(0);
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'hFFFF_FFFC;
        tick();
        branch_flag_i = 1'b0;
        checks++;
        if (inst_addr_o !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_target: addr=%h, required fffffffc", inst_addr_o);
        end
        tick();
        checks++;
        if (inst_valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC || inst_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next: valid=%b pc=%h addr=%h, required 1/fffffffc/00000000",
                     inst_valid_o, pc_o, inst_addr_o);
        end
        checks++;
        if (inst_req_o !== 1'b1) begin
            failures++;
            $display("FAIL wrap_req_live: req=%b, required 1", inst_req_o);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (inst_req_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: req=%b valid=%b pc=%h inst=%h, required 0/0/0/0",
                     inst_req_o, inst_valid_o, pc_o, inst_o);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc_refetch: req=%b addr=%h, required 1/00000000", inst_req_o, inst_addr_o);
        end
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_stall();
        test_branch_wait();
        test_exc_priority();
        test_wrap_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
